// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic-stochastic multiplier sequencer and engine wrapper.
// Pure constants/types; no latency, no flow control.
package dsc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        RESP
    } dsc_seq_state_t;

    localparam int DSC_MASK_CYC = 2;

    function automatic int dsc_res_width(input int dw, input int n);
        return dw * n;
    endfunction

    // Worst-case unary run of the engine plus a small margin.
    function automatic int dsc_max_cyc(input int res_w, input int n);
        return (1 << (res_w - n)) + 4;
    endfunction

    localparam int DSC_MAX_CYC = dsc_max_cyc(dsc_res_width(5, 2), 2);

endpackage

// File: rtl/dsc_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Single cycle update; no flow control.
module dsc_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/dsc_mul_seq_ctrl.sv
// Sequences one operand tuple through clear/run/drain of the multiplier engine and returns the product.
// Latency: RUN cycles + 3 (1 on zero-skip); one tuple in flight, in_ready low until the result handshakes.
module dsc_mul_seq_ctrl
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2,
    parameter int RES_WIDTH  = dsc_res_width(DATA_WIDTH, NUM_INPUTS),
    parameter int MASK_CYC   = DSC_MASK_CYC,
    parameter int MAX_CYC    = dsc_max_cyc(RES_WIDTH, NUM_INPUTS),
    parameter bit ZERO_SKIP  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    output logic                             mul_clr,
    output logic                             mul_en,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_opnd,
    input  logic                             mul_done,
    input  logic [RES_WIDTH-1:0]             mul_count,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RES_WIDTH-1:0]             out_data,
    output logic [RES_WIDTH:0]               out_cycles,
    output logic                             out_tmo
);

    localparam int CW = RES_WIDTH + 1;

    dsc_seq_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           accept;
    logic           any_zero;
    logic           done_ok;
    logic           tmo_hit;
    logic           tmo_q;

    assign accept  = in_valid && in_ready;
    assign done_ok = mul_done && (cnt_q >= CW'(MASK_CYC));
    assign tmo_hit = (cnt_q >= CW'(MAX_CYC - 1));

    always_comb begin
        any_zero = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (in_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (ZERO_SKIP && any_zero) ? RESP : CLEAR;
            CLEAR:   state_d = RUN;
            RUN:     if (done_ok || tmo_hit) state_d = DRAIN;
            DRAIN:   state_d = RESP;
            RESP:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    dsc_sat_counter #(.W(CW)) u_run_cnt (
        .clk (clk),
        .rst (rst),
        .clr (state_q == CLEAR),
        .inc (state_q == RUN),
        .q   (cnt_q)
    );

    // Handshake/control outputs are registered from next state so they track state exactly
    // while still holding their reset values (in_ready=0, mul_clr=1) during reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            mul_clr    <= 1'b1;
            mul_en     <= 1'b0;
            out_valid  <= 1'b0;
            mul_opnd   <= '0;
            out_data   <= '0;
            out_cycles <= '0;
            out_tmo    <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            mul_clr   <= (state_d == CLEAR);
            mul_en    <= (state_d == RUN);
            out_valid <= (state_d == RESP);
            if (accept) begin
                mul_opnd <= in_data;
            end
            if ((state_q == RUN) && (state_d == DRAIN)) begin
                tmo_q <= !done_ok;
            end
            if (state_q == DRAIN) begin
                out_data   <= mul_count;
                out_cycles <= cnt_q;
                out_tmo    <= tmo_q;
            end else if (accept && (state_d == RESP)) begin
                out_data   <= '0;
                out_cycles <= '0;
                out_tmo    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dsc_mul_seq_ctrl.sv
// Directed plus randomized bench for dsc_mul_seq_ctrl with a behavioural engine model.
module tb_dsc_mul_seq_ctrl;

    localparam int DW       = 5;
    localparam int NI       = 2;
    localparam int RW       = DW * NI;
    localparam int MASK_CYC = 2;
    localparam int MAX_CYC  = (1 << (RW - NI)) + 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RW-1:0]     in_data = '0;
    logic              mul_clr;
    logic              mul_en;
    logic [RW-1:0]     mul_opnd;
    logic              mul_done;
    logic [RW-1:0]     mul_count;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     out_data;
    logic [RW:0]       out_cycles;
    logic              out_tmo;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsc_mul_seq_ctrl #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI),
        .ZERO_SKIP  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mul_clr    (mul_clr),
        .mul_en     (mul_en),
        .mul_opnd   (mul_opnd),
        .mul_done   (mul_done),
        .mul_count  (mul_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_cycles (out_cycles),
        .out_tmo    (out_tmo)
    );

    // Engine model: counts enabled cycles since the last clear, raises done on chosen cycles.
    int run_idx   = 0;
    int done_at   = -1;
    int glitch_at = -1;

    always @(posedge clk) begin
        if (mul_clr) run_idx <= 0;
        else if (mul_en) run_idx <= run_idx + 1;
    end

    assign mul_done  = mul_en && ((run_idx == done_at) || (run_idx == glitch_at));
    assign mul_count = {5'd0, mul_opnd[DW-1:0]} * {5'd0, mul_opnd[RW-1:DW]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected result from the operands and the engine's done schedule.
    function automatic void ref_model(input int a, input int b, input int d, input int g,
                                      output int data, output int cyc, output int tmo,
                                      output int lat);
        int first;
        if (a == 0 || b == 0) begin
            data = 0; cyc = 0; tmo = 0; lat = 1;
            return;
        end
        data  = a * b;
        first = -1;
        for (int k = MASK_CYC; k < MAX_CYC; k++) begin
            if (k == d || k == g) begin
                first = k;
                break;
            end
        end
        if (first < 0) begin
            cyc = MAX_CYC; tmo = 1;
        end else begin
            cyc = first + 1; tmo = 0;
        end
        lat = cyc + 3;
    endfunction

    // Called just after a negedge; returns just after a negedge with the DUT idle.
    task automatic do_txn(input int a, input int b, input int d, input int g, input int hold);
        int e_data, e_cyc, e_tmo, e_lat;
        int lat, clr_cnt, en_cnt, first_clr, first_en, rdy_seen, waited;
        logic [RW-1:0] opnd_exp;
        ref_model(a, b, d, g, e_data, e_cyc, e_tmo, e_lat);
        opnd_exp  = {b[DW-1:0], a[DW-1:0]};
        done_at   = d;
        glitch_at = g;
        in_data   = opnd_exp;
        in_valid  = 1'b1;
        waited    = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("accept_wait", in_ready, 1);
        @(posedge clk);
        lat = 0; clr_cnt = 0; en_cnt = 0; first_clr = 0; first_en = 0; rdy_seen = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                check("opnd", mul_opnd, opnd_exp);
            end
            if (mul_clr === 1'b1) begin
                clr_cnt++;
                if (first_clr == 0) first_clr = lat;
            end
            if (mul_en === 1'b1) begin
                en_cnt++;
                if (first_en == 0) first_en = lat;
            end
            if (in_ready !== 1'b0) rdy_seen++;
        end while (out_valid !== 1'b1 && lat < MAX_CYC + 20);
        check("out_valid", out_valid, 1);
        check("latency", lat, e_lat);
        check("out_data", out_data, e_data);
        check("out_cycles", out_cycles, e_cyc);
        check("out_tmo", out_tmo, e_tmo);
        check("clr_pulses", clr_cnt, (e_lat == 1) ? 0 : 1);
        check("clr_pos", first_clr, (e_lat == 1) ? 0 : 1);
        check("en_cycles", en_cnt, e_cyc);
        check("en_pos", first_en, (e_lat == 1) ? 0 : 2);
        check("busy_in_ready", rdy_seen, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, e_data);
            check("hold_cycles", out_cycles, e_cyc);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        int ra, rb;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_mul_clr", mul_clr, 1);
        check("rst_mul_en", mul_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_cycles", out_cycles, 0);
        check("rst_out_tmo", out_tmo, 0);
        check("rst_mul_opnd", mul_opnd, 0);
        rst = 1'b1;
        #1;
        check("rel_in_ready_0", in_ready, 0);
        @(negedge clk);
        check("rel_in_ready_1", in_ready, 1);
        check("rel_mul_clr", mul_clr, 0);

        // Basic product, zero skip, held response, masked glitch
        do_txn(3, 5, 6, -1, 0);
        do_txn(0, 17, 6, -1, 0);
        do_txn(31, 31, 9, -1, 10);
        do_txn(9, 14, 12, 0, 2);

        // Mask boundary: done on cycle 1 ignored, cycle 2 accepted
        do_txn(7, 2, 1, 2, 0);
        do_txn(6, 0, 3, -1, 1);

        // Timeout, then done exactly on the timeout cycle, then a normal run
        do_txn(11, 13, -1, -1, 1);
        do_txn(21, 19, MAX_CYC - 1, -1, 0);
        do_txn(4, 4, 5, -1, 0);

        // Reset mid-RUN drops the tuple
        done_at   = -1;
        glitch_at = -1;
        in_data   = {5'd7, 5'd9};
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_run_en", mul_en, 1);
        rst = 1'b0;
        #1;
        check("arst_mul_en", mul_en, 0);
        check("arst_mul_clr", mul_clr, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arel_in_ready_0", in_ready, 0);
        @(negedge clk);
        check("arel_in_ready_1", in_ready, 1);
        stale = 0;
        repeat (MAX_CYC + 10) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || mul_en !== 1'b0) stale++;
        end
        check("no_stale", stale, 0);
        do_txn(25, 30, 20, 1, 0);

        // Randomized tuples
        for (int t = 0; t < 25; t++) begin
            ra = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
            rb = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
            do_txn(ra, rb, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
